line_window_gen: RTL

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

---
 rtl/sobel_pkg.sv | 10 +
 rtl/line_buffer.sv | 22 ++
 rtl/line_window_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared widths and default frame geometry for the line/window pipeline.
package sobel_pkg;
    localparam int COORD_W   = 11;
    localparam int PIX_W     = 8;
    localparam int IMG_W_DEF = 1280;
    localparam int IMG_H_DEF = 854;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [PIX_W-1:0]   pix_t;
endpackage

// File: rtl/line_buffer.sv
// Single-port line memory: the read is combinational, so the old word is
// visible in the same cycle that a new word is written (read-before-write).
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end

    assign dout = mem[addr];
endmodule

// File: rtl/line_window_gen.sv
// Raster-order pixel stream to 3x3 window generator with centre coordinates.
// Build option LINE_WINDOW_OUT_REG_EN adds one output register stage (latency 2).
module line_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic               CK,
    input  logic               RES,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [PIX_W-1:0]   in_pix,
    output logic [PIX_W-1:0]   S00,
    output logic [PIX_W-1:0]   S01,
    output logic [PIX_W-1:0]   S02,
    output logic [PIX_W-1:0]   S10,
    output logic [PIX_W-1:0]   S11,
    output logic [PIX_W-1:0]   S12,
    output logic [PIX_W-1:0]   S20,
    output logic [PIX_W-1:0]   S21,
    output logic [PIX_W-1:0]   S22,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_row,
    output logic [COORD_W-1:0] out_col,
    output logic               frame_done,
    output logic               sof_err
);
    localparam int     AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
    localparam coord_t LAST_ROW = coord_t'(IMG_H - 1);
    localparam coord_t ONE      = coord_t'(1);
    localparam coord_t TWO      = coord_t'(2);

    coord_t row, col, pos_row, pos_col, row_n, col_n;
    logic   accept, win_hit, last_hit;
    pix_t   lb0_q, lb1_q;

    // pos_* is where the pixel accepted this cycle lands; in_sof pins it to (0,0).
    always_comb begin
        accept  = in_valid;
        pos_row = in_sof ? '0 : row;
        pos_col = in_sof ? '0 : col;
        if (pos_col == LAST_COL) begin
            col_n = '0;
            row_n = (pos_row == LAST_ROW) ? '0 : pos_row + ONE;
        end else begin
            col_n = pos_col + ONE;
            row_n = pos_row;
        end
        win_hit  = accept && (pos_row >= TWO) && (pos_col >= TWO);
        last_hit = win_hit && (pos_row == LAST_ROW) && (pos_col == LAST_COL);
    end

    always_ff @(posedge CK or posedge RES) begin
        if (RES) begin
            row     <= '0;
            col     <= '0;
            sof_err <= 1'b0;
        end else if (accept) begin
            row <= row_n;
            col <= col_n;
            if (in_sof && ((row != '0) || (col != '0))) sof_err <= 1'b1;
        end
    end

    line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb0 (
        .clk (CK),
        .we  (accept),
        .addr(pos_col[AW-1:0]),
        .din (in_pix),
        .dout(lb0_q)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(AW)) u_lb1 (
        .clk (CK),
        .we  (accept),
        .addr(pos_col[AW-1:0]),
        .din (lb0_q),
        .dout(lb1_q)
    );

    pix_t   win [3][3];
    coord_t row1, col1;
    logic   valid1, done1;

    // Column 2 is the newest column; rows are top (r-2), middle (r-1), bottom (r).
    always_ff @(posedge CK or posedge RES) begin
        if (RES) begin
            win    <= '{default: '0};
            row1   <= '0;
            col1   <= '0;
            valid1 <= 1'b0;
            done1  <= 1'b0;
        end else begin
            valid1 <= win_hit;
            done1  <= last_hit;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1_q;
                win[1][2] <= lb0_q;
                win[2][2] <= in_pix;
            end
            if (win_hit) begin
                row1 <= pos_row - ONE;
                col1 <= pos_col - ONE;
            end
        end
    end

    pix_t   win_o [3][3];
    coord_t row_o, col_o;
    logic   valid_o, done_o;

`ifdef LINE_WINDOW_OUT_REG_EN
    always_ff @(posedge CK or posedge RES) begin
        if (RES) begin
            win_o   <= '{default: '0};
            row_o   <= '0;
            col_o   <= '0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            win_o   <= win;
            row_o   <= row1;
            col_o   <= col1;
            valid_o <= valid1;
            done_o  <= done1;
        end
    end
`else
    assign win_o   = win;
    assign row_o   = row1;
    assign col_o   = col1;
    assign valid_o = valid1;
    assign done_o  = done1;
`endif

    assign S00        = win_o[0][0];
    assign S01        = win_o[0][1];
    assign S02        = win_o[0][2];
    assign S10        = win_o[1][0];
    assign S11        = win_o[1][1];
    assign S12        = win_o[1][2];
    assign S20        = win_o[2][0];
    assign S21        = win_o[2][1];
    assign S22        = win_o[2][2];
    assign out_valid  = valid_o;
    assign out_row    = row_o;
    assign out_col    = col_o;
    assign frame_done = done_o;
endmodule
